// File: rtl/cla_pkg.sv
// Shared constants for the 8-bit carry-lookahead adder and its 4-bit groups.
// Optional feature macro used by cla_8bit: CLA_8BIT_OVF_EN (adds overflow output V).
package cla_pkg;

  // Full operand width of the adder.
  localparam int CLA_WIDTH       = 8;
  // Width of one lookahead group.
  localparam int CLA_GROUP_WIDTH = 4;
  // Number of lookahead groups making up the full adder.
  localparam int CLA_GROUPS      = CLA_WIDTH / CLA_GROUP_WIDTH;

endpackage : cla_pkg

// File: rtl/cla_4bit.sv
// Purely combinational 4-bit carry-lookahead group.
// Every internal carry and the group generate are written in flattened
// two-level sum-of-products form, so no carry ripples through the group.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_WIDTH-1:0] a,
  input  logic [CLA_GROUP_WIDTH-1:0] b,
  input  logic                       cin,
  output logic [CLA_GROUP_WIDTH-1:0] s,
  output logic                       pg,
  output logic                       gg
);

  logic [CLA_GROUP_WIDTH-1:0] g_s;
  logic [CLA_GROUP_WIDTH-1:0] p_s;
  logic [CLA_GROUP_WIDTH-1:0] c_s;

  // Bitwise generate/propagate, flattened lookahead carries, sum and group P/G.
  always_comb begin
    g_s = a & b;
    p_s = a ^ b;

    c_s[0] = cin;
    c_s[1] = g_s[0]
           | (p_s[0] & cin);
    c_s[2] = g_s[1]
           | (p_s[1] & g_s[0])
           | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2]
           | (p_s[2] & g_s[1])
           | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);

    s  = p_s ^ c_s;
    pg = &p_s;
    // Group generate: carry out of the group with its carry-in forced low.
    gg = g_s[3]
       | (p_s[3] & g_s[2])
       | (p_s[3] & p_s[2] & g_s[1])
       | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
  end

endmodule : cla_4bit

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups, with a
// single registered output stage (1-cycle latency, new operands every cycle).
// Optional macro CLA_8BIT_OVF_EN adds registered signed-overflow output V.
module cla_8bit
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic [CLA_WIDTH-1:0] S,
  output logic                 Cout,
  output logic                 PG,
  output logic                 GG,
  input  logic [CLA_WIDTH-1:0] A,
  input  logic [CLA_WIDTH-1:0] B,
  input  logic                 Cin
`ifdef CLA_8BIT_OVF_EN
  ,
  output logic                 V
`endif
);

  logic [CLA_GROUP_WIDTH-1:0] s_lo_s;
  logic [CLA_GROUP_WIDTH-1:0] s_hi_s;
  logic                       pg_lo_s;
  logic                       gg_lo_s;
  logic                       pg_hi_s;
  logic                       gg_hi_s;
  logic                       c4_s;

  logic [CLA_WIDTH-1:0] s_d;
  logic                 cout_d;
  logic                 pg_d;
  logic                 gg_d;
  logic [CLA_WIDTH-1:0] s_q;
  logic                 cout_q;
  logic                 pg_q;
  logic                 gg_q;

  // Carry into the upper group comes straight from the lower group's G/P.
  assign c4_s = gg_lo_s | (pg_lo_s & Cin);

  cla_4bit u_grp_lo (
    .a   (A[CLA_GROUP_WIDTH-1:0]),
    .b   (B[CLA_GROUP_WIDTH-1:0]),
    .cin (Cin),
    .s   (s_lo_s),
    .pg  (pg_lo_s),
    .gg  (gg_lo_s)
  );

  cla_4bit u_grp_hi (
    .a   (A[CLA_WIDTH-1:CLA_GROUP_WIDTH]),
    .b   (B[CLA_WIDTH-1:CLA_GROUP_WIDTH]),
    .cin (c4_s),
    .s   (s_hi_s),
    .pg  (pg_hi_s),
    .gg  (gg_hi_s)
  );

  // Combine group results into the next-state sum, carry and group P/G.
  always_comb begin
    s_d    = {s_hi_s, s_lo_s};
    pg_d   = pg_hi_s & pg_lo_s;
    gg_d   = gg_hi_s | (pg_hi_s & gg_lo_s);
    cout_d = gg_d | (pg_d & Cin);
  end

  // Output register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 8'h00;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign PG   = pg_q;
  assign GG   = gg_q;

`ifdef CLA_8BIT_OVF_EN
  logic c7_s;
  logic v_d;
  logic v_q;

  // Overflow is carry-out of bit 7 XOR carry-in of bit 7; the latter is
  // recovered from the bit-7 sum since S[7] = P[7] ^ C[7].
  always_comb begin
    c7_s = s_d[CLA_WIDTH-1] ^ A[CLA_WIDTH-1] ^ B[CLA_WIDTH-1];
    v_d  = cout_d ^ c7_s;
  end

  // Registered overflow flag, aligned with the sum outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  assign V = v_q;
`endif

endmodule : cla_8bit

// File: tb/tb_cla_8bit.sv
// Scoreboard bench for cla_8bit: a driver issues one operand set per cycle and
// queues the expected result tagged with the cycle it is due; a monitor pops
// and compares on the falling edge, after the inputs have already moved on.
module tb_cla_8bit;

  typedef struct {
    int          due;
    logic [7:0]  s;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        v;
    string       tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] S;
  logic       Cout;
  logic       PG;
  logic       GG;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       V_w;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  cla_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .S    (S),
    .Cout (Cout),
    .PG   (PG),
    .GG   (GG),
    .A    (A),
    .B    (B),
    .Cin  (Cin)
`ifdef CLA_8BIT_OVF_EN
    ,
    .V    (V_w)
`endif
  );

`ifndef CLA_8BIT_OVF_EN
  assign V_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to tag when each result is due.
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one operand set just after a rising edge and queue its expectation.
  task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic ec,
                       input logic epg, input logic egg, input logic ev,
                       input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; A = a; B = b; Cin = ci;
    e.due = cyc + 1; e.s = es; e.cout = ec; e.pg = epg; e.gg = egg;
    e.v = ev; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Arithmetic reference: 9-bit sum, propagate as AND of XOR bits, generate as
  // carry with Cin=0, overflow from operand/result signs.
  task automatic issue_model(input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input string tag);
    logic [8:0] sum;
    logic [8:0] sum0;
    logic       v;
    sum  = {1'b0, a} + {1'b0, b} + {8'h00, ci};
    sum0 = {1'b0, a} + {1'b0, b};
    v    = (a[7] == b[7]) && (sum[7] != a[7]);
    issue(1'b0, a, b, ci, sum[7:0], sum[8], &(a ^ b), sum0[8], v, tag);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s act=0x%02h req=0x%02h", tag, fld, act, req);
    end
  endtask

  // Monitor: compare every result that is due at this falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        cmp(e.tag, "S", S, e.s);
        cmp(e.tag, "Cout", {7'h00, Cout}, {7'h00, e.cout});
        cmp(e.tag, "PG", {7'h00, PG}, {7'h00, e.pg});
        cmp(e.tag, "GG", {7'h00, GG}, {7'h00, e.gg});
`ifdef CLA_8BIT_OVF_EN
        cmp(e.tag, "V", {7'h00, V_w}, {7'h00, e.v});
`endif
      end
    end
  end

  logic [7:0] b_list [8];

  initial begin
    int wait_cyc;
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; A = 8'h00; B = 8'h00; Cin = 1'b0;
    b_list[0] = 8'h00; b_list[1] = 8'h01; b_list[2] = 8'h0F; b_list[3] = 8'h7F;
    b_list[4] = 8'h80; b_list[5] = 8'hF0; b_list[6] = 8'hFF; b_list[7] = 8'h5A;

    // Reset with all-ones operands: everything must be zero.
    issue(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_ones");
    // Directed vectors with hand-computed results.
    issue(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "rst_release");
    issue(1'b0, 8'h00, 8'h77, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, "v00_77_0");
    issue(1'b0, 8'h00, 8'h77, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0, "v00_77_1");
    issue(1'b0, 8'h94, 8'hF7, 1'b0, 8'h8B, 1'b1, 1'b0, 1'b1, 1'b0, "v94_F7_0");
    issue(1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "v55_AA_1");
    issue(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, "v7F_01_0");
    issue(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "vFF_00_1");
    issue(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "vFF_FF_1");
    issue(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, "v80_80_0");
    // Mid-stream reset discards its operands; next result uses first rst=0 inputs.
    issue(1'b1, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
    issue(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    // Back-to-back sweep: every A against a set of edge-case B values, both Cin.
    for (int a = 0; a < 256; a++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          issue_model(a[7:0], b_list[bi] ^ a[7:0] & {8{bi == 7}}, ci[0], "sweep");
        end
      end
    end

    // Drain the scoreboard with a bounded wait.
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d req=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cla_8bit
